// File: rtl/quadrature_encoder.sv
// Quadrature (A/B) pulse generator: each accepted command emits a signed number
// of edges at a fixed spacing, tracking a wrapping signed position count.
module quadrature_encoder #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [COUNTER_WIDTH-1:0]        cmd_steps,
  input  logic [COUNTER_WIDTH-1:0]        cmd_period,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic                            out_a,
  output logic                            out_b,
  output logic signed [COUNTER_WIDTH-1:0] position,
  input  logic                            clear_position
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                    r_state;
  logic                      r_dir;        // 1 = reverse
  logic [COUNTER_WIDTH-1:0]  r_remaining;
  logic [COUNTER_WIDTH-1:0]  r_period;
  logic [COUNTER_WIDTH-1:0]  r_timer;
  logic [COUNTER_WIDTH-1:0]  r_position;
  logic                      r_a, r_b, r_done, r_aborted;

  logic                      w_accept;
  logic                      w_edge;
  logic [COUNTER_WIDTH-1:0]  w_mag;
  logic [COUNTER_WIDTH-1:0]  w_period_eff;
  logic [COUNTER_WIDTH-1:0]  w_pos_base;
  logic [COUNTER_WIDTH-1:0]  w_pos_next;

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  // Magnitude as unsigned, so the most negative step count maps to 2^(W-1).
  assign w_mag        = cmd_steps[COUNTER_WIDTH-1] ? ('0 - cmd_steps) : cmd_steps;
  assign w_period_eff = (cmd_period == '0) ? ONE : cmd_period;
  // Abort wins over an edge falling due in the same cycle.
  assign w_edge       = (r_state == S_RUN) && !abort && (r_timer == ONE);

  always_comb begin
    w_pos_base = clear_position ? '0 : r_position;
    w_pos_next = w_pos_base;
    if (w_edge)
      w_pos_next = r_dir ? (w_pos_base - ONE) : (w_pos_base + ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_period    <= ONE;
      r_timer     <= ONE;
      r_position  <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_position <= w_pos_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dir       <= cmd_steps[COUNTER_WIDTH-1];
            r_remaining <= w_mag;
            r_period    <= w_period_eff;
            r_timer     <= w_period_eff;
            if (w_mag == '0) r_done  <= 1'b1;
            else             r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_edge) begin
            // Forward 00->10->11->01: A' = ~B, B' = A; reverse is the inverse map.
            if (r_dir) begin
              r_a <= r_b;
              r_b <= ~r_a;
            end else begin
              r_a <= ~r_b;
              r_b <= r_a;
            end
            r_remaining <= r_remaining - ONE;
            r_timer     <= r_period;
            if (r_remaining == ONE) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign position  = r_position;

endmodule

// File: tb/tb_quadrature_encoder.sv
// Bench for quadrature_encoder: per-cycle checks against a closed-form model
// (edges done = min(t/period, n), phase index mod 4, position = start + dir*edges).
module tb_quadrature_encoder;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst, cmd_valid, abort, clear_position;
  logic [W-1:0]        cmd_steps, cmd_period;
  logic                cmd_ready, busy, done, aborted, out_a, out_b;
  logic signed [W-1:0] position;

  int n_pass  = 0;
  int n_total = 0;
  int m_ph    = 0;   // model phase index, 0..3 maps to AB 00,10,11,01
  int m_pos   = 0;

  quadrature_encoder #(.COUNTER_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .busy(busy),
    .done(done), .aborted(aborted), .out_a(out_a), .out_b(out_b),
    .position(position), .clear_position(clear_position)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ab_of(int ph);
    int p;
    p = ((ph % 4) + 4) % 4;
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [W-1:0] wrap(int v);
    return v[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input int steps, input int period);
    cmd_steps  = steps[W-1:0];
    cmd_period = period[W-1:0];
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_total++; if ({out_a, out_b} !== 2'b00) $display("FAIL reset_ab got %b want 00", {out_a, out_b}); else n_pass++;
    n_total++; if (position !== '0) $display("FAIL reset_pos got %0d want 0", position); else n_pass++;
    n_total++; if ({cmd_ready, busy, done, aborted} !== 4'b1000) $display("FAIL reset_ctl got %b want 1000", {cmd_ready, busy, done, aborted}); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if ({cmd_ready, busy, done, aborted} !== 4'b1000) $display("FAIL post_reset_ctl got %b want 1000", {cmd_ready, busy, done, aborted}); else n_pass++;
    m_ph = 0; m_pos = 0;
  endtask

  // Directed table (forward, reverse with period 0, zero move) followed by random moves.
  task automatic test_moves();
    int st[3] = '{4, -2, 0};
    int pr[3] = '{3, 0, 5};
    for (int i = 0; i < 23; i++) begin
      int steps, period, n, d, p, e, ph0, pos0;
      logic [1:0] exp_ab;
      logic exp_busy, exp_done;
      if (i < 3) begin steps = st[i]; period = pr[i]; end
      else begin steps = int'($urandom_range(0, 12)) - 6; period = int'($urandom_range(0, 4)); end
      n = (steps < 0) ? -steps : steps;
      d = (steps < 0) ? -1 : 1;
      p = (period == 0) ? 1 : period;
      ph0 = m_ph; pos0 = m_pos;
      issue_cmd(steps, period);
      for (int t = 0; t <= n * p + 1; t++) begin
        if (t > 0) tick();
        e = t / p;
        if (e > n) e = n;
        exp_ab   = ab_of(ph0 + d * e);
        exp_busy = (e < n);
        exp_done = (t == n * p);
        n_total++; if ({out_a, out_b} !== exp_ab) $display("FAIL move%0d_ab t=%0d got %b want %b", i, t, {out_a, out_b}, exp_ab); else n_pass++;
        n_total++; if (position !== wrap(pos0 + d * e)) $display("FAIL move%0d_pos t=%0d got %0d want %0d", i, t, position, $signed(wrap(pos0 + d * e))); else n_pass++;
        n_total++; if ({busy, cmd_ready} !== {exp_busy, !exp_busy}) $display("FAIL move%0d_busy t=%0d got %b want %b", i, t, {busy, cmd_ready}, {exp_busy, !exp_busy}); else n_pass++;
        n_total++; if ({done, aborted} !== {exp_done, 1'b0}) $display("FAIL move%0d_done t=%0d got %b want %b", i, t, {done, aborted}, {exp_done, 1'b0}); else n_pass++;
      end
      m_ph = ph0 + d * n; m_pos = pos0 + d * n;
    end
  endtask

  task automatic test_abort();
    int ph0, pos0;
    ph0 = m_ph; pos0 = m_pos;
    issue_cmd(10, 2);
    for (int t = 1; t <= 5; t++) tick();
    n_total++; if ({out_a, out_b} !== ab_of(ph0 + 2)) $display("FAIL abort_pre_ab got %b want %b", {out_a, out_b}, ab_of(ph0 + 2)); else n_pass++;
    abort = 1'b1;
    tick();   // third edge would be due here; abort must suppress it
    abort = 1'b0;
    n_total++; if ({done, aborted, busy} !== 3'b110) $display("FAIL abort_flags got %b want 110", {done, aborted, busy}); else n_pass++;
    n_total++; if ({out_a, out_b} !== ab_of(ph0 + 2)) $display("FAIL abort_ab got %b want %b", {out_a, out_b}, ab_of(ph0 + 2)); else n_pass++;
    n_total++; if (position !== wrap(pos0 + 2)) $display("FAIL abort_pos got %0d want %0d", position, $signed(wrap(pos0 + 2))); else n_pass++;
    tick();
    n_total++; if ({done, aborted, out_a, out_b} !== {2'b00, ab_of(ph0 + 2)}) $display("FAIL abort_after got %b want %b", {done, aborted, out_a, out_b}, {2'b00, ab_of(ph0 + 2)}); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if ({done, cmd_ready} !== 2'b01) $display("FAIL abort_idle got %b want 01", {done, cmd_ready}); else n_pass++;
    m_ph = ph0 + 2; m_pos = pos0 + 2;
  endtask

  task automatic test_clear_edge();
    int ph0;
    clear_position = 1'b1;
    tick();
    clear_position = 1'b0;
    n_total++; if (position !== '0) $display("FAIL clear_idle got %0d want 0", position); else n_pass++;
    ph0 = m_ph;
    issue_cmd(3, 2);
    tick(); tick(); tick();
    clear_position = 1'b1;
    tick();   // second edge coincides with the clear
    clear_position = 1'b0;
    n_total++; if (position !== wrap(1)) $display("FAIL clear_edge_pos got %0d want 1", position); else n_pass++;
    n_total++; if ({out_a, out_b} !== ab_of(ph0 + 2)) $display("FAIL clear_edge_ab got %b want %b", {out_a, out_b}, ab_of(ph0 + 2)); else n_pass++;
    tick(); tick();
    n_total++; if ({position, done} !== {wrap(2), 1'b1}) $display("FAIL clear_end got %0d/%b want 2/1", position, done); else n_pass++;
    n_total++; if ({out_a, out_b} !== ab_of(ph0 + 3)) $display("FAIL clear_end_ab got %b want %b", {out_a, out_b}, ab_of(ph0 + 3)); else n_pass++;
    m_ph = ph0 + 3; m_pos = 2;
  endtask

  task automatic test_back_to_back();
    int ph1, pos1, t2, e;
    ph1 = m_ph + 2; pos1 = m_pos + 2;
    issue_cmd(2, 2);
    cmd_steps = wrap(-3); cmd_period = 8'd3; cmd_valid = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 3) begin
        n_total++; if ({cmd_ready, busy} !== 2'b01) $display("FAIL b2b_held got %b want 01", {cmd_ready, busy}); else n_pass++;
      end
      if (t == 4) begin
        n_total++; if ({done, cmd_ready} !== 2'b11) $display("FAIL b2b_done got %b want 11", {done, cmd_ready}); else n_pass++;
        n_total++; if ({out_a, out_b} !== ab_of(ph1)) $display("FAIL b2b_ab1 got %b want %b", {out_a, out_b}, ab_of(ph1)); else n_pass++;
      end
    end
    cmd_valid = 1'b0;
    n_total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept got %b want 10", {busy, done}); else n_pass++;
    for (int t = 6; t <= 15; t++) begin
      tick();
      t2 = t - 5;
      e = t2 / 3;
      if (e > 3) e = 3;
      n_total++; if ({out_a, out_b} !== ab_of(ph1 - e)) $display("FAIL b2b_ab2 t=%0d got %b want %b", t, {out_a, out_b}, ab_of(ph1 - e)); else n_pass++;
      n_total++; if (position !== wrap(pos1 - e)) $display("FAIL b2b_pos t=%0d got %0d want %0d", t, position, $signed(wrap(pos1 - e))); else n_pass++;
      n_total++; if (done !== (t2 == 9)) $display("FAIL b2b_done2 t=%0d got %b want %b", t, done, (t2 == 9)); else n_pass++;
    end
    m_ph = ph1 - 3; m_pos = pos1 - 3;
  endtask

  task automatic test_mid_reset();
    issue_cmd(5, 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if ({out_a, out_b, position} !== {2'b00, 8'h00}) $display("FAIL mrst_vals got %b/%0d want 00/0", {out_a, out_b}, position); else n_pass++;
    n_total++; if ({cmd_ready, busy, done, aborted} !== 4'b1000) $display("FAIL mrst_ctl got %b want 1000", {cmd_ready, busy, done, aborted}); else n_pass++;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_total++; if ({done, busy, out_a, out_b} !== 4'b0000) $display("FAIL mrst_quiet t=%0d got %b want 0000", t, {done, busy, out_a, out_b}); else n_pass++;
    end
    m_ph = 0; m_pos = 0;
  endtask

  task automatic test_wrap();
    issue_cmd(127, 1);
    for (int t = 1; t <= 127; t++) tick();
    n_total++; if ({position, done} !== {wrap(127), 1'b1}) $display("FAIL wrap_127 got %0d/%b want 127/1", position, done); else n_pass++;
    issue_cmd(1, 1);
    tick();
    n_total++; if (position !== wrap(-128)) $display("FAIL wrap_neg got %0d want -128", position); else n_pass++;
    n_total++; if ({out_a, out_b} !== ab_of(128)) $display("FAIL wrap_ab got %b want %b", {out_a, out_b}, ab_of(128)); else n_pass++;
    // Most negative step count: magnitude 128 edges.
    issue_cmd(-128, 1);
    for (int t = 1; t <= 127; t++) tick();
    n_total++; if ({busy, done} !== 2'b10) $display("FAIL minneg_127 got %b want 10", {busy, done}); else n_pass++;
    tick();
    n_total++; if ({busy, done, position} !== {2'b01, 8'h00}) $display("FAIL minneg_end got %b/%0d want 01/0", {busy, done}, position); else n_pass++;
    n_total++; if ({out_a, out_b} !== ab_of(0)) $display("FAIL minneg_ab got %b want 00", {out_a, out_b}); else n_pass++;
    m_ph = 0; m_pos = 0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; clear_position = 1'b0;
    cmd_steps = '0; cmd_period = '0;
    test_reset();
    test_moves();
    test_abort();
    test_clear_edge();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
